// File: rtl/inst_fetch_unit.sv
// RV64I instruction fetch stage: owns the PC, fetches over a ready-based
// imem port and selects the next PC when the datapath retires.
module inst_fetch_unit #(
  parameter int unsigned XLEN = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_0040_0000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            pc_write_en,
  input  logic            jal_en,
  input  logic            jalr_en,
  input  logic            branch_en,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  input  logic            inst_retire,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic            inst_valid,
  output logic [31:0]     inst,
  output logic [6:0]      inst_opcode,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus_4,
  output logic            fetch_misaligned
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT,
    REQ,
    VALID,
    HALT
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] jalr_sum;
  logic [31:0]     inst_q;
  logic            req_q;
  logic            valid_q;
  logic            mis_q;
  logic            target_mis;

  assign pc_plus_4 = pc_q + XLEN'(4);
  assign jalr_sum  = rs1_data + imm;

  always_comb begin
    next_pc = pc_plus_4;
    priority case (1'b1)
      !pc_write_en:             next_pc = pc_q;
      jalr_en:                  next_pc = {jalr_sum[XLEN-1:1], 1'b0};
      jal_en:                   next_pc = pc_q + imm;
      branch_en && branch_taken: next_pc = pc_q + imm;
      default:                  next_pc = pc_plus_4;
    endcase
  end

  assign target_mis = |next_pc[1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= BOOT;
      pc_q    <= RESET_PC;
      inst_q  <= NOP;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state <= REQ;
          req_q <= 1'b1;
        end
        REQ: begin
          if (imem_ready) begin
            inst_q  <= imem_rdata;
            state   <= VALID;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        VALID: begin
          if (inst_retire) begin
            inst_q  <= NOP;
            valid_q <= 1'b0;
            // A bad target freezes the PC at the offending instruction
            if (target_mis) begin
              mis_q <= 1'b1;
              state <= HALT;
            end else begin
              pc_q  <= next_pc;
              req_q <= 1'b1;
              state <= REQ;
            end
          end
        end
        HALT: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
        default: state <= HALT;
      endcase
    end
  end

  assign imem_req         = req_q;
  assign imem_addr        = pc_q;
  assign inst_valid       = valid_q;
  assign inst             = inst_q;
  assign inst_opcode      = inst_q[6:0];
  assign pc               = pc_q;
  assign fetch_misaligned = mis_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios plus a
// randomized retire stream checked against a next-PC reference model.
module tb_inst_fetch_unit;

  localparam logic [63:0] RPC = 64'h0000_0000_0040_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clock;
  logic        reset;
  logic        pc_write_en;
  logic        jal_en;
  logic        jalr_en;
  logic        branch_en;
  logic        branch_taken;
  logic [63:0] imm;
  logic [63:0] rs1_data;
  logic        inst_retire;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [6:0]  inst_opcode;
  logic [63:0] pc;
  logic [63:0] pc_plus_4;
  logic        fetch_misaligned;

  int total = 0;
  int bad = 0;

  inst_fetch_unit dut (
    .clock(clock),
    .reset(reset),
    .pc_write_en(pc_write_en),
    .jal_en(jal_en),
    .jalr_en(jalr_en),
    .branch_en(branch_en),
    .branch_taken(branch_taken),
    .imm(imm),
    .rs1_data(rs1_data),
    .inst_retire(inst_retire),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .inst_valid(inst_valid),
    .inst(inst),
    .inst_opcode(inst_opcode),
    .pc(pc),
    .pc_plus_4(pc_plus_4),
    .fetch_misaligned(fetch_misaligned)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: architectural next-PC rule of the control inputs
  function automatic logic [63:0] model_next(
    input logic [63:0] cur, input bit we, input bit jl,
    input bit jr, input bit br, input bit tk,
    input logic [63:0] im, input logic [63:0] r1);
    if (!we) return cur;
    if (jr) return (r1 + im) & ~64'd1;
    if (jl) return cur + im;
    if (br && tk) return cur + im;
    return cur + 64'd4;
  endfunction

  task automatic clear_ctrl();
    pc_write_en = 1'b1;
    jal_en = 1'b0;
    jalr_en = 1'b0;
    branch_en = 1'b0;
    branch_taken = 1'b0;
    imm = '0;
    rs1_data = '0;
    inst_retire = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1;
    imem_ready = 1'b0;
    clear_ctrl();
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Serve one request; ends at a negedge with the word captured
  task automatic fetch(input int dly, input logic [31:0] w,
                       output logic [63:0] a, output bit stable,
                       output bit seen);
    int n = 0;
    stable = 1'b1;
    while (!imem_req && n < 50) begin
      @(negedge clock);
      n++;
    end
    seen = imem_req;
    a = imem_addr;
    if (!seen) return;
    for (int i = 0; i < dly; i++) begin
      @(negedge clock);
      if (imem_req !== 1'b1 || imem_addr !== a) stable = 1'b0;
    end
    imem_ready = 1'b1;
    imem_rdata = w;
    @(negedge clock);
    imem_ready = 1'b0;
    imem_rdata = $urandom;
  endtask

  task automatic retire(input bit we, input bit jl, input bit jr,
                        input bit br, input bit tk,
                        input logic [63:0] im, input logic [63:0] r1);
    pc_write_en = we;
    jal_en = jl;
    jalr_en = jr;
    branch_en = br;
    branch_taken = tk;
    imm = im;
    rs1_data = r1;
    inst_retire = 1'b1;
    @(negedge clock);
    clear_ctrl();
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0 ||
        inst !== NOP || pc !== RPC || fetch_misaligned !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: req=%b v=%b inst=%h pc=%h mis=%b",
               imem_req, inst_valid, inst, pc, fetch_misaligned);
    end
    imem_ready = 1'b1;
    imem_rdata = 32'h0010_0093;
    @(negedge clock);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== RPC || inst_valid !== 1'b0) begin
      bad++;
      $display("FAIL boot_req: req=%b addr=%h v=%b want 1 %h 0",
               imem_req, imem_addr, inst_valid, RPC);
    end
    @(negedge clock);
    imem_ready = 1'b0;
    total++;
    if (inst_valid !== 1'b1 || inst_opcode !== 7'h13 ||
        inst !== 32'h0010_0093 || imem_req !== 1'b0) begin
      bad++;
      $display("FAIL first_fetch: v=%b op=%h inst=%h req=%b",
               inst_valid, inst_opcode, inst, imem_req);
    end
  endtask

  task automatic test_sequential();
    logic [63:0] a;
    bit st, sn;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      fetch(3, 32'h0000_0013 + 32'(i << 7), a, st, sn);
      total++;
      if (!sn || !st || a !== RPC + 64'(4 * i)) begin
        bad++;
        $display("FAIL seq_addr%0d: addr=%h want %h seen=%b stable=%b",
                 i, a, RPC + 64'(4 * i), sn, st);
      end
      retire(1, 0, 0, 0, 0, '0, '0);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] a;
    bit st, sn;
    apply_reset();
    fetch(0, 32'h0000_006f, a, st, sn);
    retire(1, 0, 0, 0, 0, '0, '0);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== RPC + 64'd4 ||
        inst_valid !== 1'b0 || inst !== NOP) begin
      bad++;
      $display("FAIL b2b_req: req=%b addr=%h v=%b inst=%h",
               imem_req, imem_addr, inst_valid, inst);
    end
  endtask

  task automatic test_jumps();
    logic [63:0] a;
    bit st, sn;
    apply_reset();
    fetch(1, 32'h0100_006f, a, st, sn);
    retire(1, 1, 0, 0, 0, 64'h10, '0);
    fetch(0, 32'hff9f_f06f, a, st, sn);
    total++;
    if (a !== 64'h40_0010) begin
      bad++;
      $display("FAIL jal_setup: addr=%h want 400010", a);
    end
    retire(1, 1, 0, 0, 0, -64'sd8, '0);
    fetch(2, 32'h0000_8067, a, st, sn);
    total++;
    if (a !== 64'h40_0008) begin
      bad++;
      $display("FAIL jal_back: addr=%h want 400008", a);
    end
    retire(1, 0, 1, 0, 0, '0, 64'h50_0003);
    total++;
    if (fetch_misaligned !== 1'b1 || imem_req !== 1'b0 ||
        inst_valid !== 1'b0 || pc !== 64'h40_0008) begin
      bad++;
      $display("FAIL jalr_mis: mis=%b req=%b v=%b pc=%h",
               fetch_misaligned, imem_req, inst_valid, pc);
    end
    imem_ready = 1'b1;
    retire(1, 0, 0, 0, 0, '0, '0);
    repeat (3) @(negedge clock);
    imem_ready = 1'b0;
    total++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0 ||
        fetch_misaligned !== 1'b1 || pc !== 64'h40_0008) begin
      bad++;
      $display("FAIL halt_hold: req=%b v=%b mis=%b pc=%h",
               imem_req, inst_valid, fetch_misaligned, pc);
    end
    apply_reset();
    total++;
    if (fetch_misaligned !== 1'b0) begin
      bad++;
      $display("FAIL mis_clear: mis=%b want 0", fetch_misaligned);
    end
  endtask

  task automatic test_branch();
    logic [63:0] a;
    bit st, sn;
    apply_reset();
    fetch(0, 32'h0200_0063, a, st, sn);
    retire(1, 0, 0, 1, 1, 64'h20, '0);
    fetch(0, NOP, a, st, sn);
    total++;
    if (a !== 64'h40_0020) begin
      bad++;
      $display("FAIL br_taken: addr=%h want 400020", a);
    end
    apply_reset();
    fetch(0, 32'h0200_0063, a, st, sn);
    retire(1, 0, 0, 1, 0, 64'h20, '0);
    fetch(0, NOP, a, st, sn);
    total++;
    if (a !== 64'h40_0004) begin
      bad++;
      $display("FAIL br_not_taken: addr=%h want 400004", a);
    end
    apply_reset();
    fetch(0, NOP, a, st, sn);
    retire(0, 1, 0, 0, 0, 64'h40, '0);
    fetch(0, NOP, a, st, sn);
    total++;
    if (a !== RPC) begin
      bad++;
      $display("FAIL no_write: addr=%h want %h", a, RPC);
    end
  endtask

  task automatic test_wrap();
    logic [63:0] a;
    bit st, sn;
    apply_reset();
    fetch(0, NOP, a, st, sn);
    retire(1, 0, 1, 0, 0, '0, 64'hFFFF_FFFF_FFFF_FFFC);
    fetch(0, NOP, a, st, sn);
    total++;
    if (a !== 64'hFFFF_FFFF_FFFF_FFFC || pc_plus_4 !== 64'd0) begin
      bad++;
      $display("FAIL wrap_top: addr=%h p4=%h want fffffffffffffffc 0",
               a, pc_plus_4);
    end
    retire(1, 0, 0, 0, 0, '0, '0);
    fetch(0, NOP, a, st, sn);
    total++;
    if (a !== 64'd0 || fetch_misaligned !== 1'b0) begin
      bad++;
      $display("FAIL wrap_zero: addr=%h mis=%b want 0 0",
               a, fetch_misaligned);
    end
  endtask

  task automatic test_reset_mid_req();
    apply_reset();
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    total++;
    if (imem_req !== 1'b0 || pc !== RPC || inst !== NOP) begin
      bad++;
      $display("FAIL async_reset: req=%b pc=%h inst=%h",
               imem_req, pc, inst);
    end
    imem_ready = 1'b1;
    imem_rdata = 32'hdead_beef;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    imem_ready = 1'b0;
    total++;
    if (inst_valid !== 1'b0 || inst !== NOP || imem_req !== 1'b1) begin
      bad++;
      $display("FAIL late_ready: v=%b inst=%h req=%b want 0 %h 1",
               inst_valid, inst, imem_req, NOP);
    end
  endtask

  task automatic test_random();
    logic [63:0] a, exp_pc, im, r1;
    logic [31:0] w;
    bit st, sn, we, jl, jr, br, tk;
    int dly;
    apply_reset();
    exp_pc = RPC;
    for (int i = 0; i < 40; i++) begin
      dly = $urandom_range(0, 3);
      w = $urandom;
      fetch(dly, w, a, st, sn);
      total++;
      if (!sn || !st || a !== exp_pc || inst !== w ||
          inst_opcode !== w[6:0] || inst_valid !== 1'b1 ||
          pc_plus_4 !== exp_pc + 64'd4) begin
        bad++;
        $display("FAIL rnd%0d: addr=%h want %h inst=%h want %h st=%b",
                 i, a, exp_pc, inst, w, st);
      end
      we = ($urandom_range(0, 7) != 0);
      jl = ($urandom_range(0, 3) == 0);
      jr = ($urandom_range(0, 3) == 0);
      br = $urandom_range(0, 1);
      tk = $urandom_range(0, 1);
      im = 64'(signed'({$urandom_range(0, 255), 2'b00}) - 512);
      r1 = {$urandom, $urandom} & ~64'd2;
      exp_pc = model_next(exp_pc, we, jl, jr, br, tk, im, r1);
      retire(we, jl, jr, br, tk, im, r1);
    end
  endtask

  initial begin
    reset = 1'b1;
    imem_ready = 1'b0;
    imem_rdata = '0;
    clear_ctrl();
    test_reset();
    test_sequential();
    test_back_to_back();
    test_jumps();
    test_branch();
    test_wrap();
    test_reset_mid_req();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
